scan_decoder: RTL



---
 rtl/scan_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/scan_decoder.sv
// scan_decoder -- registered binary-to-one-hot decoder with an optional
// free-running line scanner.
//
// Decode mode (mode=0): each sel accepted via in_valid/in_ready shows up one
// cycle later as out = 1 << sel and is held until the next accepted sel.
// Scan mode (mode=1): out walks from bit 0 to bit 2**SEL_W-1 and wraps.
// Each line is held dwell+1 cycles, and wrap pulses on the first cycle
// back at bit 0.
//
// Build option: define SCAN_DECODER_SCAN_EN to include the scan mode, the
// dwell counter and the wrap logic. Without it, mode=1 leaves the block idle,
// wrap stays 0 and dwell is ignored.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   en         block enable; 0 returns the block to idle
//   mode       0 = decode, 1 = scan
//   in_valid   sel is valid (decode mode)
//   in_ready   sel is accepted this cycle
//   sel        index to decode
//   dwell      extra cycles each scan line is held
//   out        registered one-hot (or all-zero) output
//   out_valid  out holds a decoded or scanned line
//   cur_sel    binary index of the asserted out bit
//   wrap       one-cycle pulse when the scan wraps to bit 0
//
// state  | meaning
// IDLE   | outputs cleared, waiting for en
// DECODE | decode mode, out holds the last accepted sel
// SCAN   | scan mode, out walks through the lines
module scan_decoder #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    sel,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [2**SEL_W-1:0] out,
  output logic                out_valid,
  output logic [SEL_W-1:0]    cur_sel,
  output logic                wrap
);

  localparam int N = 2**SEL_W;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]     out_nxt;
  logic             out_valid_nxt;
  logic [SEL_W-1:0] cur_sel_nxt;
  logic             wrap_nxt;

`ifdef SCAN_DECODER_SCAN_EN
  logic [DWELL_W-1:0] cnt, cnt_nxt;
`else
  logic unused_dwell;
  assign unused_dwell = ^dwell;
`endif

  assign in_ready = ((state == ST_IDLE) || (state == ST_DECODE)) && en && !mode;

  always_comb begin
    state_nxt     = state;
    out_nxt       = out;
    out_valid_nxt = out_valid;
    cur_sel_nxt   = cur_sel;
    wrap_nxt      = 1'b0;
`ifdef SCAN_DECODER_SCAN_EN
    cnt_nxt       = cnt;
`endif
    case (state)
      ST_IDLE, ST_DECODE: begin
        if (en && !mode) begin
          state_nxt = ST_DECODE;
          if (in_valid) begin
            out_nxt       = ONE << sel;
            cur_sel_nxt   = sel;
            out_valid_nxt = 1'b1;
          end
        end else if (en && (state == ST_IDLE)) begin
`ifdef SCAN_DECODER_SCAN_EN
          state_nxt     = ST_SCAN;
          out_nxt       = ONE;
          cur_sel_nxt   = '0;
          out_valid_nxt = 1'b1;
          cnt_nxt       = dwell;
`else
          state_nxt = ST_IDLE;
`endif
        end else begin
          // en low, or a mode change while decoding
          state_nxt     = ST_IDLE;
          out_nxt       = '0;
          out_valid_nxt = 1'b0;
          cur_sel_nxt   = '0;
        end
      end
`ifdef SCAN_DECODER_SCAN_EN
      ST_SCAN: begin
        if (!en || !mode) begin
          state_nxt     = ST_IDLE;
          out_nxt       = '0;
          out_valid_nxt = 1'b0;
          cur_sel_nxt   = '0;
          cnt_nxt       = '0;
        end else if (cnt == '0) begin
          // rotate so the top line falls back to bit 0; dwell is re-sampled
          // here because a new line starts on the next cycle
          out_nxt     = {out[N-2:0], out[N-1]};
          cur_sel_nxt = cur_sel + SEL_W'(1);
          wrap_nxt    = (cur_sel == {SEL_W{1'b1}});
          cnt_nxt     = dwell;
        end else begin
          cnt_nxt = cnt - DWELL_W'(1);
        end
      end
`endif
      default: begin
        state_nxt     = ST_IDLE;
        out_nxt       = '0;
        out_valid_nxt = 1'b0;
        cur_sel_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      cur_sel   <= '0;
      wrap      <= 1'b0;
`ifdef SCAN_DECODER_SCAN_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
      cur_sel   <= cur_sel_nxt;
      wrap      <= wrap_nxt;
`ifdef SCAN_DECODER_SCAN_EN
      cnt       <= cnt_nxt;
`endif
    end
  end

endmodule
